// File: rtl/calc1_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc1_sched_pkg
// Purpose  : Shared types and constants for the calc1 request scheduler.
//            Holds the scheduler state encoding, calc1 command and response
//            codes, the default response timeout, and the small helpers used
//            by both the arbiter and the scheduler.
// Revision : 1.0  initial release
// ============================================================================
package calc1_sched_pkg;

    localparam int NUM_REQ = 4;
    localparam int CMD_W   = 4;
    localparam int DATA_W  = 32;
    localparam int RESP_W  = 2;

    // Number of WAIT cycles before a missing response is declared lost.
    localparam int DEFAULT_TIMEOUT = 16;

    // Scheduler states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    // calc1 command codes
    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    // calc1 response codes (RESP_TIMEOUT is generated locally, never by calc1)
    localparam logic [RESP_W-1:0] RESP_NONE    = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK      = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR     = 2'd2;
    localparam logic [RESP_W-1:0] RESP_TIMEOUT = 2'd3;

    // Requester vectors are big-endian: bit 0 (leftmost) is requester 0.
    function automatic logic [0:NUM_REQ-1] idx_to_onehot(input logic [1:0] idx);
        logic [0:NUM_REQ-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : 4-way round-robin arbiter with internal priority pointer.
//            The search for a requester starts at the pointer; after each
//            grant the pointer moves to the slot just past the winner.
// Ports    : clk           - clock, rising edge
//            rst_n         - synchronous active-low reset (pointer -> 0)
//            i_enable      - grants are only issued while high
//            i_req[0:3]    - request vector, bit 0 = requester 0
//            o_grant[0:3]  - one-hot grant (combinational)
//            o_grant_idx   - index of the granted requester
//            o_grant_valid - a grant is being issued this cycle
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter4
    import calc1_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [0:NUM_REQ-1] i_req,
    output logic [0:NUM_REQ-1] o_grant,
    output logic [1:0]         o_grant_idx,
    output logic               o_grant_valid
);

    logic [1:0] r_ptr;
    logic [1:0] w_cand;
    logic [1:0] w_idx;
    logic       w_found;

    // Scan the four slots starting at the pointer; the first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        w_cand  = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_grant_valid = i_enable && w_found;
    assign o_grant_idx   = w_idx;
    assign o_grant       = o_grant_valid ? idx_to_onehot(w_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (o_grant_valid) begin
            r_ptr <= w_idx + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/calc1_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : calc1_req_scheduler
// Purpose  : Shares one calc1 port between four requesters. A round-robin
//            arbiter picks a requester in IDLE; the command and op1 are
//            presented to calc1, op2 on the following cycle, then the
//            scheduler waits for a response (or times out) and returns a
//            one-cycle completion pulse to the owning requester.
// Ports    : c_clk          - clock, rising edge
//            reset          - synchronous active-low reset
//            req_valid[0:3] - pending request per requester (bit 0 = req 0)
//            req_cmd        - 4-bit command per requester, req i at [4i:4i+3]
//            req_op1/op2    - 32-bit operands, req i at [32i:32i+31]
//            req_ready      - one-hot grant, operands captured while high
//            done_valid     - one-hot completion pulse
//            done_resp/data - completion response code and result
//            calc_cmd_out   - to calc1 req_cmd_in
//            calc_data_out  - to calc1 req_data_in
//            calc_resp_in   - from calc1 out_resp
//            calc_data_in   - from calc1 out_data
// Revision : 1.0  initial release
// ============================================================================
module calc1_req_scheduler
    import calc1_sched_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
    input  logic                      c_clk,
    input  logic                      reset,
    input  logic [0:NUM_REQ-1]        req_valid,
    input  logic [0:NUM_REQ*CMD_W-1]  req_cmd,
    input  logic [0:NUM_REQ*DATA_W-1] req_op1,
    input  logic [0:NUM_REQ*DATA_W-1] req_op2,
    output logic [0:NUM_REQ-1]        req_ready,
    output logic [0:NUM_REQ-1]        done_valid,
    output logic [RESP_W-1:0]         done_resp,
    output logic [DATA_W-1:0]         done_data,
    output logic [CMD_W-1:0]          calc_cmd_out,
    output logic [DATA_W-1:0]         calc_data_out,
    input  logic [RESP_W-1:0]         calc_resp_in,
    input  logic [DATA_W-1:0]         calc_data_in
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    sched_state_t         r_state,      w_state_nxt;
    logic [CMD_W-1:0]     r_cmd_out,    w_cmd_out_nxt;
    logic [DATA_W-1:0]    r_data_out,   w_data_out_nxt;
    logic [DATA_W-1:0]    r_op2,        w_op2_nxt;
    logic [1:0]           r_owner,      w_owner_nxt;
    logic [7:0]           r_cnt,        w_cnt_nxt;
    logic [0:NUM_REQ-1]   r_done_valid, w_done_valid_nxt;
    logic [RESP_W-1:0]    r_done_resp,  w_done_resp_nxt;
    logic [DATA_W-1:0]    r_done_data,  w_done_data_nxt;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               w_arb_enable;
    logic [0:NUM_REQ-1] w_grant;
    logic [1:0]         w_grant_idx;
    logic               w_grant_valid;

    // Holding reset low also suppresses grants so nothing is captured.
    assign w_arb_enable = (r_state == ST_IDLE) && reset;

    rr_arbiter4 u_arb (
        .clk           (c_clk),
        .rst_n         (reset),
        .i_enable      (w_arb_enable),
        .i_req         (req_valid),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign req_ready = w_grant;

    // Select the granted requester's command and operands.
    logic [CMD_W-1:0]  w_sel_cmd;
    logic [DATA_W-1:0] w_sel_op1;
    logic [DATA_W-1:0] w_sel_op2;

    always_comb begin
        w_sel_cmd = '0;
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == 2'(k)) begin
                w_sel_cmd = req_cmd[CMD_W*k +: CMD_W];
                w_sel_op1 = req_op1[DATA_W*k +: DATA_W];
                w_sel_op2 = req_op2[DATA_W*k +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cmd_out_nxt    = r_cmd_out;
        w_data_out_nxt   = r_data_out;
        w_op2_nxt        = r_op2;
        w_owner_nxt      = r_owner;
        w_cnt_nxt        = r_cnt;
        w_done_valid_nxt = '0;           // completion is a single-cycle pulse
        w_done_resp_nxt  = r_done_resp;
        w_done_data_nxt  = r_done_data;

        unique case (r_state)
            ST_IDLE: begin
                // calc_resp_in is deliberately ignored here (spurious).
                if (w_grant_valid) begin
                    w_owner_nxt = w_grant_idx;
                    if (w_sel_cmd != CMD_NOP) begin
                        w_cmd_out_nxt  = w_sel_cmd;
                        w_data_out_nxt = w_sel_op1;
                        w_op2_nxt      = w_sel_op2;
                        w_state_nxt    = ST_OP2;
                    end else begin
                        // NOP completes immediately without touching calc1.
                        w_done_valid_nxt = idx_to_onehot(w_grant_idx);
                        w_done_resp_nxt  = RESP_NONE;
                        w_done_data_nxt  = '0;
                    end
                end
            end

            ST_OP2: begin
                w_cmd_out_nxt  = '0;
                w_data_out_nxt = r_op2;
                w_cnt_nxt      = '0;
                w_state_nxt    = ST_WAIT;
            end

            ST_WAIT: begin
                w_cmd_out_nxt  = '0;
                w_data_out_nxt = '0;
                // A real response takes priority over a coincident timeout.
                if (calc_resp_in != RESP_NONE) begin
                    w_done_valid_nxt = idx_to_onehot(r_owner);
                    w_done_resp_nxt  = calc_resp_in;
                    w_done_data_nxt  = calc_data_in;
                    w_state_nxt      = ST_IDLE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_done_valid_nxt = idx_to_onehot(r_owner);
                    w_done_resp_nxt  = RESP_TIMEOUT;
                    w_done_data_nxt  = '0;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cmd_out    <= '0;
            r_data_out   <= '0;
            r_op2        <= '0;
            r_owner      <= 2'd0;
            r_cnt        <= '0;
            r_done_valid <= '0;
            r_done_resp  <= '0;
            r_done_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd_out    <= w_cmd_out_nxt;
            r_data_out   <= w_data_out_nxt;
            r_op2        <= w_op2_nxt;
            r_owner      <= w_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_done_valid <= w_done_valid_nxt;
            r_done_resp  <= w_done_resp_nxt;
            r_done_data  <= w_done_data_nxt;
        end
    end

    assign calc_cmd_out  = r_cmd_out;
    assign calc_data_out = r_data_out;
    assign done_valid    = r_done_valid;
    assign done_resp     = r_done_resp;
    assign done_data     = r_done_data;

endmodule

`default_nettype wire

// File: tb/tb_calc1_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc1_req_scheduler
// Purpose  : Directed self-checking bench for calc1_req_scheduler. The bench
//            plays the calc1 side by hand, driving responses at fixed points.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc1_req_scheduler;

    logic          c_clk;
    logic          reset;
    logic [0:3]    req_valid;
    logic [0:15]   req_cmd;
    logic [0:127]  req_op1;
    logic [0:127]  req_op2;
    logic [0:3]    req_ready;
    logic [0:3]    done_valid;
    logic [1:0]    done_resp;
    logic [31:0]   done_data;
    logic [3:0]    calc_cmd_out;
    logic [31:0]   calc_data_out;
    logic [1:0]    calc_resp_in;
    logic [31:0]   calc_data_in;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit finished = 1'b0;

    calc1_req_scheduler #(.TIMEOUT(16)) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_ready     (req_ready),
        .done_valid    (done_valid),
        .done_resp     (done_resp),
        .done_data     (done_data),
        .calc_cmd_out  (calc_cmd_out),
        .calc_data_out (calc_data_out),
        .calc_resp_in  (calc_resp_in),
        .calc_data_in  (calc_data_in)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] cmd,
                           input logic [31:0] op1, input logic [31:0] op2);
        req_cmd[4*i +: 4]  = cmd;
        req_op1[32*i +: 32] = op1;
        req_op2[32*i +: 32] = op2;
    endtask

    initial begin
        #20000;
        if (!finished) begin
            $display("FAIL watchdog: observed timeout expected finish");
            $fatal(1, "simulation watchdog expired");
        end
    end

    initial begin
        reset        = 1'b0;
        req_valid    = '0;
        req_cmd      = '0;
        req_op1      = '0;
        req_op2      = '0;
        calc_resp_in = '0;
        calc_data_in = '0;

        // ---------------- reset state ----------------
        step();
        req_valid = 4'b1111;
        step();
        chk("rst_ready",     req_ready,     4'b0000);
        chk("rst_done",      done_valid,    4'b0000);
        chk("rst_cmd",       calc_cmd_out,  4'h0);
        chk("rst_data",      calc_data_out, 32'h0);
        chk("rst_resp",      done_resp,     2'd0);

        // ---------------- round robin with NOPs ----------------
        reset = 1'b1;
        #1;
        chk("rr_g0", req_ready, 4'b1000);
        step();
        chk("rr_d0", done_valid, 4'b1000);
        chk("rr_g1", req_ready, 4'b0100);
        step();
        chk("rr_d1", done_valid, 4'b0100);
        chk("rr_g2", req_ready, 4'b0010);
        step();
        chk("rr_d2", done_valid, 4'b0010);
        chk("rr_g3", req_ready, 4'b0001);
        step();
        chk("rr_d3", done_valid, 4'b0001);
        chk("rr_g0b", req_ready, 4'b1000);
        req_valid = 4'b1010;
        step();
        chk("alt_2a", req_ready, 4'b0010);
        step();
        chk("alt_0", req_ready, 4'b1000);
        step();
        chk("alt_2b", req_ready, 4'b0010);
        chk("nop_cmd", calc_cmd_out, 4'h0);
        step();
        req_valid = 4'b0000;
        #1;
        chk("alt_d2", done_valid, 4'b0010);
        chk("alt_resp", done_resp, 2'd0);
        step();
        chk("pulse_clr", done_valid, 4'b0000);

        // ---------------- req0 ADD, OK response ----------------
        set_req(0, 4'd1, 32'h00000001, 32'h01FFFFFF);
        req_valid = 4'b1000;
        #1;
        chk("add_ready", req_ready, 4'b1000);
        step();
        req_valid = 4'b0000;
        chk("add_cmd", calc_cmd_out, 4'd1);
        chk("add_op1", calc_data_out, 32'h00000001);
        step();
        chk("add_cmd0", calc_cmd_out, 4'd0);
        chk("add_op2", calc_data_out, 32'h01FFFFFF);
        calc_resp_in = 2'd1;
        calc_data_in = 32'h02000000;
        step();
        calc_resp_in = 2'd0;
        calc_data_in = 32'h0;
        chk("add_dv", done_valid, 4'b1000);
        chk("add_resp", done_resp, 2'd1);
        chk("add_data", done_data, 32'h02000000);
        chk("add_wait0", calc_data_out, 32'h0);

        // ---------------- spurious response in IDLE ----------------
        calc_resp_in = 2'd1;
        calc_data_in = 32'h55555555;
        step();
        step();
        chk("spur_dv", done_valid, 4'b0000);
        calc_resp_in = 2'd0;
        calc_data_in = 32'h0;

        // ---------------- req2 SUB, ERR response ----------------
        set_req(2, 4'd2, 32'h00000001, 32'h0000000F);
        req_valid = 4'b0010;
        #1;
        chk("sub_ready", req_ready, 4'b0010);
        step();
        req_valid = 4'b0000;
        chk("sub_cmd", calc_cmd_out, 4'd2);
        chk("sub_op1", calc_data_out, 32'h1);
        step();
        chk("sub_op2", calc_data_out, 32'hF);
        calc_resp_in = 2'd2;
        calc_data_in = 32'h0;
        step();
        calc_resp_in = 2'd0;
        chk("sub_dv", done_valid, 4'b0010);
        chk("sub_resp", done_resp, 2'd2);
        chk("sub_data", done_data, 32'h0);

        // ---------------- req3 timeout ----------------
        set_req(3, 4'd1, 32'h12345678, 32'h9ABCDEF0);
        req_valid = 4'b0001;
        #1;
        chk("to_ready", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        step();                        // first WAIT cycle
        calc_data_in = 32'hDEADBEEF;   // data without a response is ignored
        for (int i = 0; i < 15; i++) step();
        chk("to_early", done_valid, 4'b0000);
        step();
        chk("to_dv", done_valid, 4'b0001);
        chk("to_resp", done_resp, 2'd3);
        chk("to_data", done_data, 32'h0);
        calc_data_in = 32'h0;

        // ---------------- req1 NOP ----------------
        set_req(1, 4'd0, 32'hAAAA0000, 32'hBBBB0000);
        req_valid = 4'b0100;
        #1;
        chk("nop_ready", req_ready, 4'b0100);
        step();
        req_valid = 4'b0000;
        chk("nop_dv", done_valid, 4'b0100);
        chk("nop_resp", done_resp, 2'd0);
        chk("nop_data", done_data, 32'h0);
        chk("nop_cmd1", calc_cmd_out, 4'd0);

        // ---------------- reset during WAIT ----------------
        set_req(3, 4'd1, 32'h00000010, 32'h00000020);
        req_valid = 4'b0001;
        #1;
        chk("rw_ready", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        step();                        // in WAIT
        reset = 1'b0;
        step();
        chk("rw_cmd", calc_cmd_out, 4'd0);
        chk("rw_data", calc_data_out, 32'h0);
        chk("rw_dv", done_valid, 4'b0000);
        reset = 1'b1;
        calc_resp_in = 2'd1;           // late response for the dropped request
        calc_data_in = 32'h77777777;
        step();
        chk("rw_late", done_valid, 4'b0000);
        calc_resp_in = 2'd0;
        calc_data_in = 32'h0;
        req_valid = 4'b0001;
        #1;
        chk("rw_ready2", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        chk("rw_cmd2", calc_cmd_out, 4'd1);
        chk("rw_op1", calc_data_out, 32'h10);
        step();
        chk("rw_op2", calc_data_out, 32'h20);
        calc_resp_in = 2'd1;
        calc_data_in = 32'h30;
        step();
        calc_resp_in = 2'd0;
        calc_data_in = 32'h0;
        chk("rw_dv2", done_valid, 4'b0001);
        chk("rw_resp2", done_resp, 2'd1);
        chk("rw_data2", done_data, 32'h30);

        finished = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
